// File: rtl/ram_io_resp_pkg.sv
// Shared constants for the RAM / memory-mapped IO responder.
// Pure definitions: no logic, no latency.
// Holds the IO map, the IO-select mask and the read/write encoding of mem_wr.
package ram_io_resp_pkg;

  localparam logic [31:0] IO_BASE     = 32'h0003_0000;  // byte stream data register
  localparam logic [31:0] IO_STATUS   = 32'h0003_0004;  // status / halt register
  localparam logic [31:0] IO_SEL_MASK = 32'h0003_0000;  // bits [17:16] both set -> IO

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  // Bits above 17 are ignored; only a[17:16] == 2'b11 selects IO space.
  function automatic logic is_io(input logic [31:0] a);
    return (a & IO_SEL_MASK) == IO_SEL_MASK;
  endfunction

endpackage

// File: rtl/ram_io_resp_byte_fifo.sv
// Byte FIFO with combinational head (first-word fall-through), pointer-based storage.
// Latency: a pushed byte is visible at dout the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop completes in the same cycle;
//   pop is ignored when empty. No overflow tracking here; the parent decides.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, empty, full.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = data_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; emptiness is carried by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !rst) data_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ram_io_resp.sv
// Byte RAM plus memory-mapped IO (in/out byte FIFOs, status, sticky halt flag).
// Latency: reads return on mem_dout one cycle after the address cycle; writes take effect at that edge.
// Backpressure: in_ready = input FIFO not full; output-FIFO writes while full are dropped and
//   flagged in overflow unless out_ready frees a slot in the same cycle.
// Ports: clk, rst; mem_a/mem_din/mem_wr/mem_dout (initiator); in_valid/in_data/in_ready;
//   out_valid/out_data/out_ready; io_full; program_finish.
module ram_io_resp
  import ram_io_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_din,
  input  logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        io_full,
  output logic        program_finish
);

  mem_op_e                 op;
  logic                    io_sel;
  logic [17:0]             io_off;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic                    is_rd, is_wr;
  logic                    ram_we, ram_re;
  logic                    io_wr_data, io_wr_stat, io_rd_data, io_rd_stat;
  logic                    unused_mem_a;

  assign op           = mem_op_e'(mem_wr);
  assign io_sel       = is_io(mem_a);
  assign io_off       = mem_a[17:0];
  assign ram_addr     = mem_a[ADDR_WIDTH-1:0];
  assign unused_mem_a = ^mem_a[31:18];
  assign is_rd        = (op == MEM_READ);
  assign is_wr        = (op == MEM_WRITE);

  // Nothing is written or popped during a reset cycle.
  assign ram_we     = is_wr && !io_sel && !rst;
  assign ram_re     = is_rd && !io_sel && !rst;
  assign io_wr_data = is_wr && io_sel && (io_off == IO_BASE[17:0]);
  assign io_wr_stat = is_wr && io_sel && (io_off == IO_STATUS[17:0]);
  assign io_rd_data = is_rd && io_sel && (io_off == IO_BASE[17:0]);
  assign io_rd_stat = is_rd && io_sel && (io_off == IO_STATUS[17:0]);

  // FIFOs
  logic [7:0] in_dout;
  logic       in_empty, in_full, out_empty, out_full;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .din   (in_data),
    .pop   (io_rd_data),
    .dout  (in_dout),
    .empty (in_empty),
    .full  (in_full)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io_wr_data),
    .din   (mem_din),
    .pop   (out_ready),
    .dout  (out_data),
    .empty (out_empty),
    .full  (out_full)
  );

  assign in_ready  = !in_full;
  assign out_valid = !out_empty;
  assign io_full   = out_full;

  // RAM: synchronous read port, no reset, read data held across writes.
  logic [7:0] ram [2**ADDR_WIDTH];
  logic [7:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= mem_din;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  // Control / IO registers
  logic       rd_ram_q, rd_ram_d;     // mem_dout sourced from RAM (1) or IO read data (0)
  logic [7:0] io_rdata_q, io_rdata_d;
  logic       overflow_q, overflow_d;
  logic       finish_q, finish_d;

  always_comb begin
    rd_ram_d   = rd_ram_q;
    io_rdata_d = io_rdata_q;
    overflow_d = overflow_q;
    finish_d   = finish_q;
    if (is_rd) begin
      rd_ram_d   = !io_sel;
      io_rdata_d = 8'h00;
      if (io_rd_data && !in_empty) io_rdata_d = in_dout;
      else if (io_rd_stat)         io_rdata_d = {5'b0, overflow_q, !in_empty, out_full};
    end
    // When full, out_valid is 1, so out_ready alone decides whether a slot opens.
    if (io_wr_data && out_full && !out_ready) overflow_d = 1'b1;
    if (io_wr_stat) finish_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ram_q   <= 1'b0;
      io_rdata_q <= 8'h00;
      overflow_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      rd_ram_q   <= rd_ram_d;
      io_rdata_q <= io_rdata_d;
      overflow_q <= overflow_d;
      finish_q   <= finish_d;
    end
  end

  assign mem_dout       = rd_ram_q ? ram_rdata : io_rdata_q;
  assign program_finish = finish_q;

endmodule

// File: tb/tb_ram_io_resp.sv
// Self-checking bench for ram_io_resp: directed scenarios then randomized traffic,
// scored against a queue/array model of the memory map.
module tb_ram_io_resp;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_din = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        io_full;
  logic        program_finish;

  ram_io_resp #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_a          (mem_a),
    .mem_din        (mem_din),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .io_full        (io_full),
    .program_finish (program_finish)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] ram_m [int];
  int         waddrs[$];
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  logic       ovf = 1'b0;
  logic       fin = 1'b0;

  // Scoreboards
  logic [7:0] rd_exp[$];
  logic [7:0] out_exp[$];
  logic       rd_act = 1'b0;
  logic       rd_pend = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Read-response monitor: one cycle after a checked read was presented.
  always @(posedge clk) rd_pend <= rd_act;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp.size() == 0) begin
        errors++;
        $display("FAIL rd_scoreboard_empty actual=%0h at %0t", mem_dout, $time);
      end else begin
        chk("mem_dout", 32'(mem_dout), 32'(rd_exp.pop_front()));
      end
    end
  end

  // Output-stream monitor: compares every accepted byte.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (out_exp.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected actual=%0h required=none at %0t", out_data, $time);
      end else begin
        chk("out_data", 32'(out_data), 32'(out_exp.pop_front()));
      end
    end
  end

  function automatic logic [31:0] rnd_hi(input logic [17:0] low);
    logic [31:0] r;
    r = $urandom();
    return {r[31:18], low};
  endfunction

  // RAM address with random ignored bits and, where legal, bit 17 set (aliases RAM).
  function automatic logic [31:0] ram_addr(input logic [16:0] ra);
    logic b17;
    b17 = ra[16] ? 1'b0 : 1'($urandom_range(0, 1));
    return rnd_hi({b17, ra});
  endfunction

  // One initiator cycle: check state flags, drive inputs, advance model, take the edge.
  task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] d,
                      input logic iv, input logic [7:0] id, input logic ordy);
    logic        io, full_pre, in_full_pre, in_ne, popped, chk_rd;
    logic [17:0] off;
    logic [7:0]  e;
    int          ra;
    chk("in_ready", 32'(in_ready), 32'(in_q.size() != DEPTH));
    chk("io_full", 32'(io_full), 32'(out_q.size() == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(out_q.size() != 0));
    chk("program_finish", 32'(program_finish), 32'(fin));
    mem_wr = wr; mem_a = a; mem_din = d;
    in_valid = iv; in_data = id; out_ready = ordy;
    io          = (a[17:16] == 2'b11);
    off         = a[17:0];
    ra          = int'(a[16:0]);
    full_pre    = (out_q.size() == DEPTH);
    in_full_pre = (in_q.size() == DEPTH);
    in_ne       = (in_q.size() != 0);
    popped      = ordy && (out_q.size() != 0);
    if (popped) out_exp.push_back(out_q.pop_front());
    chk_rd = 1'b0;
    if (!wr) begin
      e = 8'h00;
      chk_rd = 1'b1;
      if (!io) begin
        if (ram_m.exists(ra)) e = ram_m[ra];
        else chk_rd = 1'b0;
      end else if (off == 18'h30000) begin
        if (in_q.size() != 0) e = in_q.pop_front();
      end else if (off == 18'h30004) begin
        e = {5'b0, ovf, in_ne, full_pre};
      end
      if (chk_rd) rd_exp.push_back(e);
    end else begin
      if (!io) begin
        if (!ram_m.exists(ra)) waddrs.push_back(ra);
        ram_m[ra] = d;
      end else if (off == 18'h30000) begin
        if (!full_pre || popped) out_q.push_back(d);
        else ovf = 1'b1;
      end else if (off == 18'h30004) begin
        fin = 1'b1;
      end
    end
    if (iv && !in_full_pre) in_q.push_back(id);
    rd_act = chk_rd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 8'h0, 1'b0, 8'h0, ordy);
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_act = 1'b0;
    mem_wr = 1'b0; mem_a = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_io_full", 32'(io_full), 32'h0);
    chk("rst_program_finish", 32'(program_finish), 32'h0);
    in_q.delete(); out_q.delete();
    ovf = 1'b0; fin = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pct;
    logic [16:0] ra17;
    logic [7:0]  other_off;
    int k;
    do_reset();

    // Single write then read-back
    step(1'b1, 32'h10, 8'hA5, 1'b0, 8'h0, 1'b0);
    step(1'b0, 32'h10, 8'h00, 1'b0, 8'h0, 1'b0);
    idle(1, 1'b0);

    // Back-to-back writes, reads in reverse order
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + i, 8'(8'h11 * (i + 1)), 1'b0, 8'h0, 1'b0);
    for (int i = 3; i >= 0; i--) step(1'b0, 32'h100 + i, 8'h00, 1'b0, 8'h0, 1'b0);
    idle(1, 1'b0);

    // Output FIFO overflow: 17 writes with sink stalled, status, then drain
    for (int i = 0; i < 17; i++) step(1'b1, 32'h30000, 8'(8'h40 + i), 1'b0, 8'h0, 1'b0);
    step(1'b0, 32'h30004, 8'h00, 1'b0, 8'h0, 1'b0);
    chk("status_after_overflow", 32'(rd_exp.size() > 0 ? rd_exp[$] : 8'hFF), 32'h05);
    idle(18, 1'b1);

    // Input stream: push one byte, read data register twice
    step(1'b0, 32'h0, 8'h00, 1'b1, 8'h7E, 1'b0);
    step(1'b0, 32'h30000, 8'h00, 1'b0, 8'h0, 1'b0);
    step(1'b0, 32'h30000, 8'h00, 1'b0, 8'h0, 1'b0);
    idle(1, 1'b0);

    // Halt flag is sticky until reset
    step(1'b1, 32'h30004, 8'h99, 1'b0, 8'h0, 1'b0);
    idle(3, 1'b0);
    do_reset();

    // Full output FIFO written while the sink drains: accepted, no overflow
    for (int i = 0; i < 16; i++) step(1'b1, 32'h30000, 8'(8'hC0 + i), 1'b0, 8'h0, 1'b0);
    step(1'b1, 32'h30000, 8'hEE, 1'b0, 8'h0, 1'b1);
    step(1'b0, 32'h30004, 8'h00, 1'b0, 8'h0, 1'b0);
    idle(20, 1'b1);

    // Fill input FIFO while reading it in the same cycle it is full
    for (int i = 0; i < 17; i++) step(1'b0, 32'h0, 8'h0, 1'b1, 8'(i), 1'b0);
    step(1'b0, 32'h30000, 8'h00, 1'b1, 8'hAB, 1'b0);
    step(1'b0, 32'h30004, 8'h00, 1'b0, 8'h0, 1'b0);

    // Randomized traffic; reset in the middle with bytes buffered
    for (int c = 0; c < 700; c++) begin
      if (c == 350) begin
        for (int j = 0; j < 5; j++) step(1'b1, 32'h30000, 8'($urandom()), 1'b1, 8'($urandom()), 1'b0);
        do_reset();
      end
      pct = (c < 350) ? 25 : 70;
      k = $urandom_range(0, 9);
      case (k)
        0, 1: begin
          ra17 = 17'($urandom_range(0, 31));
          if ($urandom_range(0, 1) == 1) ra17 = ra17 | 17'h1FFE0;
          step(1'b1, ram_addr(ra17), 8'($urandom()), 1'($urandom_range(0, 1)), 8'($urandom()),
               1'($urandom_range(0, 99) < pct));
        end
        2, 3: begin
          if (waddrs.size() != 0) ra17 = 17'(waddrs[$urandom_range(0, waddrs.size() - 1)]);
          else ra17 = '0;
          step(1'b0, ram_addr(ra17), 8'h0, 1'($urandom_range(0, 1)), 8'($urandom()),
               1'($urandom_range(0, 99) < pct));
        end
        4, 5: step(1'b1, rnd_hi(18'h30000), 8'($urandom()), 1'($urandom_range(0, 1)),
                   8'($urandom()), 1'($urandom_range(0, 99) < pct));
        6: step(1'b0, rnd_hi(18'h30000), 8'h0, 1'($urandom_range(0, 1)), 8'($urandom()),
                1'($urandom_range(0, 99) < pct));
        7: step(1'b0, rnd_hi(18'h30004), 8'h0, 1'($urandom_range(0, 1)), 8'($urandom()),
                1'($urandom_range(0, 99) < pct));
        8: begin
          other_off = 8'($urandom_range(1, 3));
          if ($urandom_range(0, 1) == 1) other_off = 8'h08;
          step(1'($urandom_range(0, 1)), rnd_hi(18'h30000 | 18'(other_off)), 8'($urandom()),
               1'($urandom_range(0, 1)), 8'($urandom()), 1'($urandom_range(0, 99) < pct));
        end
        default: begin
          if ($urandom_range(0, 39) == 0)
            step(1'b1, rnd_hi(18'h30004), 8'($urandom()), 1'b0, 8'h0, 1'($urandom_range(0, 99) < pct));
          else
            step(1'b0, 32'h0, 8'h0, 1'($urandom_range(0, 1)), 8'($urandom()),
                 1'($urandom_range(0, 99) < pct));
        end
      endcase
    end

    idle(DEPTH + 4, 1'b1);
    chk("rd_scoreboard_drained", 32'(rd_exp.size()), 32'h0);
    chk("out_scoreboard_drained", 32'(out_exp.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
